muldiv_iter: RTL and testbench

Multi-cycle multiply/divide unit that sits beside the single-cycle ALU in the execute stage and handles operations too costly for one cycle. It uses the same SrcA/SrcB/Operation operand interface as the ALU, wrapped in valid/ready handshakes in both directions. The hazard/stall logic holds the pipeline from issue until the result is consumed. Implementation is radix-2 iterative: one shift-add or shift-subtract step per cycle.

---
 rtl/muldiv_iter.sv | 125 ++++++++++++
 tb/tb_muldiv_iter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply/divide unit beside the execute-stage ALU.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
module muldiv_iter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_WIDTH-1:0]    Result,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [OPCODE_LENGTH-1:0] OP_MUL   = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] OP_MULHU = OPCODE_LENGTH'(4'b0101);
  localparam logic [OPCODE_LENGTH-1:0] OP_DIVU  = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OP_REMU  = OPCODE_LENGTH'(4'b0111);
  localparam logic [OPCODE_LENGTH-1:0] OP_DIV   = OPCODE_LENGTH'(4'b1100);
  localparam logic [OPCODE_LENGTH-1:0] OP_REM   = OPCODE_LENGTH'(4'b1101);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                   state, state_nxt;
  logic [OPCODE_LENGTH-1:0] op;
  logic [W-1:0]             opb;
  logic [2*W-1:0]           acc, acc_step, mul_step, div_step;
  logic [CW-1:0]            cnt;
  logic                     neg_q, neg_r;
  logic [W:0]               mul_sum, div_shift, div_trial;
  logic                     qbit;
  logic [W-1:0]             div_rem;
  logic [W-1:0]             result_nxt;
  logic                     accept, sdiv_in, mul_in, is_mul;

  function automatic logic [W-1:0] sign_fix(input logic [W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign accept  = (state == IDLE) && in_valid;
  assign sdiv_in = (Operation == OP_DIV) || (Operation == OP_REM);
  assign mul_in  = (Operation == OP_MUL) || (Operation == OP_MULHU);
  assign is_mul  = (op == OP_MUL) || (op == OP_MULHU);

  // Multiply step: conditionally add multiplicand to the high half, shift right
  assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : '0);
  assign mul_step = {mul_sum, acc[W-1:1]};

  // Restoring divide step: remainder in the high half, quotient shifts into the low half
  assign div_shift = {acc[2*W-1:W], acc[W-1]};
  assign div_trial = div_shift - {1'b0, opb};
  assign qbit      = ~div_trial[W];
  assign div_rem   = qbit ? div_trial[W-1:0] : div_shift[W-1:0];
  assign div_step  = {div_rem, acc[W-2:0], qbit};

  assign acc_step = is_mul ? mul_step : div_step;

  always_comb begin
    result_nxt = '0;
    case (op)
      OP_MUL:   result_nxt = acc_step[W-1:0];
      OP_MULHU: result_nxt = acc_step[2*W-1:W];
      OP_DIVU:  result_nxt = acc_step[W-1:0];
      OP_REMU:  result_nxt = acc_step[2*W-1:W];
      OP_DIV:   result_nxt = sign_fix(acc_step[W-1:0], neg_q);
      OP_REM:   result_nxt = sign_fix(acc_step[2*W-1:W], neg_r);
      default:  result_nxt = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Result    <= '0;
      cnt       <= '0;
      op        <= '0;
      opb       <= '0;
      acc       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      if (accept) begin
        op    <= Operation;
        cnt   <= CW'(W);
        // Signed divides iterate on magnitudes; a zero divisor keeps the all-ones quotient
        neg_q <= sdiv_in && (SrcA[W-1] ^ SrcB[W-1]) && (SrcB != '0);
        neg_r <= sdiv_in && SrcA[W-1];
        if (mul_in) begin
          acc <= {{W{1'b0}}, SrcB};
          opb <= SrcA;
        end else begin
          acc <= {{W{1'b0}}, sign_fix(SrcA, sdiv_in && SrcA[W-1])};
          opb <= sign_fix(SrcB, sdiv_in && SrcB[W-1]);
        end
      end else if (state == CALC) begin
        acc <= acc_step;
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) Result <= result_nxt;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: latency, results, backpressure, reset abort.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] SrcA, SrcB;
  logic [3:0]  Operation;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] Result;

  int checks = 0;
  int errors = 0;

  muldiv_iter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset), .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .in_valid(in_valid), .in_ready(in_ready), .Result(Result),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present a request and return #1 after the edge that accepts it
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("issue_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges from accept to out_valid, check result, consume if out_ready
  task automatic wait_done(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!out_valid && n < 100);
    check({tag, "_lat"}, n, 32);
    check(tag, Result, exp);
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int bad;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    SrcA = '0; SrcB = '0; Operation = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", Result, 32'd0);
    reset = 1'b1;

    // 1: MUL 7*6 with ready/valid timing
    issue(4'b0100, 32'd7, 32'd6);
    check("mul_in_ready_drop", {31'b0, in_ready}, 32'd0);
    wait_done("mul_7x6", 32'd42);
    check("mul_in_ready_back", {31'b0, in_ready}, 32'd1);
    check("mul_out_valid_low", {31'b0, out_valid}, 32'd0);

    // 2: full-width products
    issue(4'b0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mulhu_max", 32'hFFFF_FFFE);
    issue(4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mul_max", 32'h0000_0001);

    // 3: signed and unsigned division
    issue(4'b1100, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_m7_2", 32'hFFFF_FFFD);
    issue(4'b1101, 32'hFFFF_FFF9, 32'd2);
    wait_done("rem_m7_2", 32'hFFFF_FFFF);
    issue(4'b0110, 32'd100, 32'd7);
    wait_done("divu_100_7", 32'd14);
    issue(4'b0111, 32'd100, 32'd7);
    wait_done("remu_100_7", 32'd2);
    issue(4'b1100, 32'd7, 32'hFFFF_FFFE);
    wait_done("div_7_m2", 32'hFFFF_FFFD);

    // 4: divide by zero and signed overflow
    issue(4'b0110, 32'd5, 32'd0);
    wait_done("divu_by0", 32'hFFFF_FFFF);
    issue(4'b1101, 32'd5, 32'd0);
    wait_done("rem_by0", 32'd5);
    issue(4'b1100, 32'hFFFF_FFF9, 32'd0);
    wait_done("div_neg_by0", 32'hFFFF_FFFF);
    issue(4'b1101, 32'hFFFF_FFF9, 32'd0);
    wait_done("rem_neg_by0", 32'hFFFF_FFF9);
    issue(4'b1100, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 32'h8000_0000);
    issue(4'b1101, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("rem_ovf", 32'd0);

    // 5: backpressure holds the result and blocks new requests
    out_ready = 1'b0;
    issue(4'b0110, 32'd9, 32'd3);
    wait_done("bp_divu_9_3", 32'd3);
    Operation = 4'b0100; SrcA = 32'd5; SrcB = 32'd5; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!out_valid || Result != 32'd3 || in_ready) bad++;
    end
    check("bp_hold", bad, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_ready", {31'b0, in_ready}, 32'd1);
    check("bp_idle_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_accepted", {31'b0, in_ready}, 32'd0);
    wait_done("bp_mul_5x5", 32'd25);

    // 6: reset mid-calculation aborts, then unit works again
    issue(4'b0110, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_result", Result, 32'd0);
    bad = 0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      if (out_valid) bad++;
    end
    check("abort_no_valid", bad, 0);
    issue(4'b0100, 32'd3, 32'd4);
    wait_done("mul_3x4", 32'd12);
    issue(4'b1010, 32'd123, 32'd45);
    wait_done("unsupported", 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
